// File: rtl/sync_fifo_flex.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_flex
// Brief    : Synchronous FIFO, any depth, standard or FWFT read, thresholds.
// Revision : 1.0
// ============================================================================
module sync_fifo_flex #(
    parameter int DEPTH     = 32,
    parameter int WIDTH     = 32,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wr,
    input  logic                       rd,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       emp,
    output logic                       full,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] c_PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] c_DEPTH    = CW'(DEPTH);
    localparam logic [CW-1:0] c_AF       = CW'(AF_THRESH);
    localparam logic [CW-1:0] c_AE       = CW'(AE_THRESH);
    localparam logic [CW-1:0] c_ONE      = CW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_dout;
    logic             r_ovf;
    logic             r_unf;

    logic             w_clr;
    logic             w_emp;
    logic             w_full;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic             w_pop;

    // Explicit wrap so non-power-of-two depths index only valid entries.
    function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] ptr);
        return (ptr == c_PTR_LAST) ? '0 : ptr + PW'(1);
    endfunction

    assign w_clr    = rst | flush;
    assign w_full   = (r_count == c_DEPTH);
    assign w_wr_acc = wr & ~w_full & ~w_clr;
    assign w_rd_acc = rd & ~w_emp & ~w_clr;

    generate
        if (FWFT != 0) begin : g_fwft
            logic          r_ov;
            logic [CW-1:0] r_mcnt;

            // Refill the output stage whenever it is free or being consumed.
            assign w_emp = ~r_ov;
            assign w_pop = (~r_ov | w_rd_acc) & (r_mcnt != '0) & ~w_clr;

            always_ff @(posedge clk) begin
                if (w_clr) begin
                    r_ov   <= 1'b0;
                    r_mcnt <= '0;
                    r_dout <= '0;
                end else begin
                    if (w_pop) begin
                        r_ov   <= 1'b1;
                        r_dout <= r_mem[r_rd_ptr];
                    end else if (w_rd_acc) begin
                        r_ov   <= 1'b0;
                    end
                    case ({w_wr_acc, w_pop})
                        2'b10:   r_mcnt <= r_mcnt + c_ONE;
                        2'b01:   r_mcnt <= r_mcnt - c_ONE;
                        default: r_mcnt <= r_mcnt;
                    endcase
                end
            end
        end else begin : g_std
            assign w_emp = (r_count == '0);
            assign w_pop = w_rd_acc;

            always_ff @(posedge clk) begin
                if (w_clr) begin
                    r_dout <= '0;
                end else if (w_pop) begin
                    r_dout <= r_mem[r_rd_ptr];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= f_next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next_ptr(r_rd_ptr);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
            if (wr & w_full) begin
                r_ovf <= 1'b1;
            end
            if (rd & w_emp) begin
                r_unf <= 1'b1;
            end
        end
    end

    assign data_out     = r_dout;
    assign emp          = w_emp;
    assign full         = w_full;
    assign almost_full  = (r_count >= c_AF);
    assign almost_empty = (r_count <= c_AE);
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;
endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_flex.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_flex
// Brief    : Directed self-checking bench for standard and FWFT FIFO builds.
// Revision : 1.0
// ============================================================================
module tb_sync_fifo_flex;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_flush = 1'b0, s_wr = 1'b0, s_rd = 1'b0;
    logic [7:0] s_din = '0, s_dout;
    logic       s_emp, s_full, s_af, s_ae, s_ovf, s_unf;
    logic [2:0] s_cnt;
    logic       f_flush = 1'b0, f_wr = 1'b0, f_rd = 1'b0;
    logic [7:0] f_din = '0, f_dout;
    logic       f_emp, f_full, f_af, f_ae, f_ovf, f_unf;
    logic [2:0] f_cnt;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sync_fifo_flex #(.DEPTH(5), .WIDTH(8), .FWFT(0), .AF_THRESH(4), .AE_THRESH(1)) u_std (
        .clk(clk), .rst(rst), .flush(s_flush), .wr(s_wr), .rd(s_rd), .data_in(s_din),
        .data_out(s_dout), .emp(s_emp), .full(s_full), .almost_full(s_af),
        .almost_empty(s_ae), .count(s_cnt), .overflow(s_ovf), .underflow(s_unf));

    sync_fifo_flex #(.DEPTH(5), .WIDTH(8), .FWFT(1), .AF_THRESH(4), .AE_THRESH(1)) u_fwft (
        .clk(clk), .rst(rst), .flush(f_flush), .wr(f_wr), .rd(f_rd), .data_in(f_din),
        .data_out(f_dout), .emp(f_emp), .full(f_full), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_cnt), .overflow(f_ovf), .underflow(f_unf));

    typedef struct {
        logic       rst, flush, wr, rd;
        logic [7:0] din;
        logic [7:0] dout;
        logic [2:0] cnt;
        logic       emp, full, af, ae, ovf, unf;
    } vec_t;

    vec_t tv[26];

    function automatic vec_t mk(input int r, fl, w, rr, di, dout, cnt, e, fu, af, ae, ov, un);
        vec_t v;
        v.rst = 1'(r);  v.flush = 1'(fl); v.wr = 1'(w); v.rd = 1'(rr); v.din = 8'(di);
        v.dout = 8'(dout); v.cnt = 3'(cnt); v.emp = 1'(e); v.full = 1'(fu);
        v.af = 1'(af); v.ae = 1'(ae); v.ovf = 1'(ov); v.unf = 1'(un);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            rst fl wr rd din    dout  cnt emp full af ae ovf unf
        tv[0]  = mk(1, 0, 0, 0, 'h00, 'h00, 0, 1, 0, 0, 1, 0, 0);
        tv[1]  = mk(0, 0, 1, 0, 'h11, 'h00, 1, 0, 0, 0, 1, 0, 0);
        tv[2]  = mk(0, 0, 1, 0, 'h12, 'h00, 2, 0, 0, 0, 0, 0, 0);
        tv[3]  = mk(0, 0, 1, 0, 'h13, 'h00, 3, 0, 0, 0, 0, 0, 0);
        tv[4]  = mk(0, 0, 1, 0, 'h14, 'h00, 4, 0, 0, 1, 0, 0, 0);
        tv[5]  = mk(0, 0, 1, 0, 'h15, 'h00, 5, 0, 1, 1, 0, 0, 0);
        tv[6]  = mk(0, 0, 1, 0, 'h99, 'h00, 5, 0, 1, 1, 0, 1, 0);
        tv[7]  = mk(0, 0, 1, 1, 'h98, 'h11, 4, 0, 0, 1, 0, 1, 0);
        tv[8]  = mk(0, 0, 0, 1, 'h00, 'h12, 3, 0, 0, 0, 0, 1, 0);
        tv[9]  = mk(0, 0, 1, 1, 'h16, 'h13, 3, 0, 0, 0, 0, 1, 0);
        tv[10] = mk(0, 0, 0, 1, 'h00, 'h14, 2, 0, 0, 0, 0, 1, 0);
        tv[11] = mk(0, 0, 0, 1, 'h00, 'h15, 1, 0, 0, 0, 1, 1, 0);
        tv[12] = mk(0, 0, 0, 1, 'h00, 'h16, 0, 1, 0, 0, 1, 1, 0);
        tv[13] = mk(0, 0, 0, 1, 'h00, 'h16, 0, 1, 0, 0, 1, 1, 1);
        tv[14] = mk(0, 0, 1, 1, 'h21, 'h16, 1, 0, 0, 0, 1, 1, 1);
        tv[15] = mk(0, 0, 1, 0, 'h22, 'h16, 2, 0, 0, 0, 0, 1, 1);
        tv[16] = mk(0, 0, 1, 0, 'h23, 'h16, 3, 0, 0, 0, 0, 1, 1);
        tv[17] = mk(0, 0, 1, 0, 'h24, 'h16, 4, 0, 0, 1, 0, 1, 1);
        tv[18] = mk(0, 1, 1, 0, 'h25, 'h00, 0, 1, 0, 0, 1, 0, 0);
        tv[19] = mk(0, 0, 1, 0, 'h31, 'h00, 1, 0, 0, 0, 1, 0, 0);
        tv[20] = mk(0, 0, 1, 0, 'h32, 'h00, 2, 0, 0, 0, 0, 0, 0);
        tv[21] = mk(0, 0, 0, 1, 'h00, 'h31, 1, 0, 0, 0, 1, 0, 0);
        tv[22] = mk(1, 0, 0, 1, 'h00, 'h00, 0, 1, 0, 0, 1, 0, 0);
        tv[23] = mk(0, 0, 0, 1, 'h00, 'h00, 0, 1, 0, 0, 1, 0, 1);
        tv[24] = mk(0, 0, 1, 0, 'h41, 'h00, 1, 0, 0, 0, 1, 0, 1);
        tv[25] = mk(0, 0, 0, 1, 'h00, 'h41, 0, 1, 0, 0, 1, 0, 1);

        // Standard-mode table: one clock edge per row, outputs checked after it.
        for (int i = 0; i < 26; i++) begin
            rst = tv[i].rst; s_flush = tv[i].flush; s_wr = tv[i].wr;
            s_rd = tv[i].rd; s_din = tv[i].din;
            edge_settle();
            chk($sformatf("std[%0d].data_out", i), 32'(s_dout), 32'(tv[i].dout));
            chk($sformatf("std[%0d].count", i),    32'(s_cnt),  32'(tv[i].cnt));
            chk($sformatf("std[%0d].emp", i),      32'(s_emp),  32'(tv[i].emp));
            chk($sformatf("std[%0d].full", i),     32'(s_full), 32'(tv[i].full));
            chk($sformatf("std[%0d].almost_full", i),  32'(s_af), 32'(tv[i].af));
            chk($sformatf("std[%0d].almost_empty", i), 32'(s_ae), 32'(tv[i].ae));
            chk($sformatf("std[%0d].overflow", i),  32'(s_ovf), 32'(tv[i].ovf));
            chk($sformatf("std[%0d].underflow", i), 32'(s_unf), 32'(tv[i].unf));
        end
        rst = 1'b0; s_wr = 1'b0; s_rd = 1'b0; s_flush = 1'b0;

        // FWFT: single word into an empty FIFO.
        rst = 1'b1;
        edge_settle();
        rst = 1'b0;
        chk("fwft.rst.emp", 32'(f_emp), 32'd1);
        chk("fwft.rst.data_out", 32'(f_dout), 32'd0);
        f_wr = 1'b1; f_din = 8'hA5;
        edge_settle();
        f_wr = 1'b0;
        chk("fwft.wr.count", 32'(f_cnt), 32'd1);
        chk("fwft.wr.emp_lag", 32'(f_emp), 32'd1);
        edge_settle();
        chk("fwft.fall.emp", 32'(f_emp), 32'd0);
        chk("fwft.fall.data_out", 32'(f_dout), 32'hA5);
        chk("fwft.fall.count", 32'(f_cnt), 32'd1);
        f_rd = 1'b1;
        edge_settle();
        f_rd = 1'b0;
        chk("fwft.rd.emp", 32'(f_emp), 32'd1);
        chk("fwft.rd.count", 32'(f_cnt), 32'd0);
        chk("fwft.rd.underflow", 32'(f_unf), 32'd0);

        // FWFT streaming: 3 writes, 9 write+read, 3 reads; pointers wrap twice.
        begin
            int wi = 0;
            int ri = 0;
            int ecnt = 0;
            for (int c = 0; c < 15; c++) begin
                f_wr = (c < 12);
                f_rd = (c >= 3);
                f_din = 8'(8'hC0 + wi);
                if (f_rd) begin
                    chk($sformatf("fwft.stream[%0d].emp", c), 32'(f_emp), 32'd0);
                    chk($sformatf("fwft.stream[%0d].data_out", c), 32'(f_dout), 32'(8'hC0 + ri));
                    ri++;
                end
                if (f_wr) wi++;
                ecnt = ecnt + (f_wr ? 1 : 0) - (f_rd ? 1 : 0);
                edge_settle();
                chk($sformatf("fwft.stream[%0d].count", c), 32'(f_cnt), 32'(ecnt));
            end
            f_wr = 1'b0; f_rd = 1'b0;
            chk("fwft.stream.end_emp", 32'(f_emp), 32'd1);
            chk("fwft.stream.overflow", 32'(f_ovf), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
